imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot sequencer for the single-cycle RISC-V core. It holds the core in reset, receives a program image as a byte stream over a valid/ready handshake, and writes it word by word into the instruction memory. When the checksum matches, it releases the core so it fetches from `BASE_ADDR`. It sits between the external load interface and the processor's reset input and instruction-memory write port.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word. Must be word-aligned.
- `MAX_WORDS`, default 256: capacity of the instruction memory in 32-bit words.

Ports:
- `clk`, input, 1: the single clock.
- `PCreset`, input, 1: system reset, synchronous, active-high.
- `rx_valid`, input, 1: a byte is offered on `rx_data`.
- `rx_data`, input, 8: stream byte.
- `rx_ready`, output, 1: the loader accepts a byte this cycle.
- `reload`, input, 1: single-cycle request to restart loading from RUN or ERROR.
- `imem_we`, output, 1: instruction-memory write strobe, one cycle per word.
- `imem_addr`, output, 32: byte address of the word being written.
- `imem_wdata`, output, 32: the assembled word.
- `core_reset`, output, 1: drives the processor's PC reset. High in every state except RUN.
- `done`, output, 1: high in RUN.
- `err`, output, 1: high in ERROR.
- `words_loaded`, output, 16: number of words written since the last load started.

## Operation
- Stream format: LEN_LO, LEN_HI (N, 16-bit little-endian word count), then 4·N data bytes with each word little-endian, then one CHK byte.
- A byte transfers on a cycle where `rx_valid && rx_ready`. Cycles with no transfer change nothing.
- FSM states are LEN_LO, LEN_HI, DATA, CHECK, RUN and ERROR. The reset state is LEN_LO.
- LEN_LO → LEN_HI on transfer.
- LEN_HI, on transfer:
  - N > MAX_WORDS → ERROR.
  - N = 0 → CHECK.
  - otherwise → DATA.
- DATA:
  - A 2-bit byte counter shifts each byte into `imem_wdata[8k+7:8k]`.
  - On the 4th byte of a word, write that word and increment `words_loaded`.
  - After word N−1, go to CHECK.
- CHECK, on transfer:
  - CHK equals the running XOR of all data bytes (initial 0x00) → RUN.
  - Otherwise → ERROR.
  - With N = 0, CHK must be 0x00.
- RUN and ERROR: `rx_ready` = 0. These states hold until `reload`, which goes to LEN_LO, clears `words_loaded`, the checksum and the byte counter, and raises `core_reset`.
- `reload` in LEN_LO, LEN_HI, DATA or CHECK is ignored.
- Words already written before an ERROR are not erased. ERROR only keeps the core in reset.

## Timing
- Reset values: state LEN_LO, `rx_ready` 0 while `PCreset` is high, `core_reset` 1, `imem_we` 0, `imem_addr` BASE_ADDR, `imem_wdata` 0, `words_loaded` 0, `done` 0, `err` 0.
- `rx_ready` is decoded from state only, never from `rx_valid`. It is 1 in LEN_LO, LEN_HI, DATA and CHECK, starting the first cycle after `PCreset` falls.
- `imem_we` is registered. It pulses for exactly one cycle, the cycle after the 4th byte of a word transfers.
- `imem_addr` = BASE_ADDR + 4·index and `imem_wdata` is the full word, both valid during that pulse.
- `words_loaded` updates in the same cycle as the pulse.
- Back-to-back bytes are accepted every cycle. The write pulse does not stall the stream.
- `core_reset` falls and `done` rises on the cycle after the correct CHK transfers. The core's first fetch is the following edge.
- `err` rises on the cycle after the failing transfer, either CHK or an oversize LEN_HI.
- `PCreset` mid-load aborts immediately and returns everything to reset values on the next edge.
- `reload` has one-cycle latency: `core_reset` = 1 and `rx_ready` = 1 on the next cycle.

## Structure
- Shared package `boot_pkg`:
  - state enum `boot_state_t`
  - `LEN_BYTES` = 2
  - `WORD_BYTES` = 4
  - `CHK_INIT` = 8'h00
- One natural sub-module, `word_packer`:
  - byte counter, 32-bit shift/assembly register, and the `word_ready` pulse
  - reset and clear by `clear`
- The FSM, address counter, checksum and status outputs live in `imem_boot_loader`.

## Test plan
- Load N=2, words 0x00500093, 0x00A00113, CHK = XOR of the 8 bytes, back-to-back. Expect:
  - `imem_we` pulses at addr 0x0 then 0x4 with those words;
  - `words_loaded` = 2;
  - `core_reset` falls one cycle after CHK.
- Same image with CHK off by 1 → `err` = 1, `core_reset` stays 1, `rx_ready` = 0, both words still written.
- LEN = 257 (0x01,0x01) with MAX_WORDS = 256 → ERROR after LEN_HI, no `imem_we` ever.
- N=0, CHK = 0x00 → RUN with `words_loaded` = 0 and no writes.
- N=1 with `rx_valid` toggling randomly → the same single write, no duplicate or dropped bytes. Then `reload` in RUN → `core_reset` = 1 next cycle and a fresh load writes from BASE_ADDR again.
- `PCreset` asserted after 3 data bytes → all outputs return to reset values. A subsequent full load succeeds with correct addresses.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } boot_state_t;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [7:0]  CHK_INIT   = 8'h00;

  // States in which the loader accepts stream bytes.
  function automatic logic is_loading(boot_state_t s);
    return (s != S_RUN) && (s != S_ERROR);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words and pulses word_ready_o once per word.
module word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  localparam int unsigned CW = $clog2(WORD_BYTES);

  logic [CW-1:0]             cnt_q;
  logic [8*WORD_BYTES-1:0]   word_q;
  logic                      ready_q;

  assign last_byte_o  = (cnt_q == CW'(WORD_BYTES - 1));
  assign word_o       = word_q;
  assign word_ready_o = ready_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= byte_valid_i && last_byte_o;
      if (byte_valid_i) begin
        word_q[8*cnt_q +: 8] <= byte_i;
        cnt_q                <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, loads a length-prefixed, XOR-checked image into IMEM.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               PCreset,
  imem_boot_loader_if.slave  bus,
  input  logic               reload,
  output logic               core_reset,
  output logic               done,
  output logic               err,
  output logic [15:0]        words_loaded
);

  boot_state_t               state_q, state_d;
  logic [8*LEN_BYTES-1:0]    len_q;
  logic [7:0]                chk_q;
  logic [15:0]               wl_q;
  logic [31:0]               addr_q;
  logic                      rx_ready_q, core_reset_q, done_q, err_q;

  logic                      xfer, data_byte, restart, last_word;
  logic [15:0]               n_in;
  logic                      pk_last, pk_ready;
  logic [31:0]               pk_word;

  assign xfer      = bus.rx_valid && rx_ready_q;
  assign data_byte = xfer && (state_q == S_DATA);
  assign restart   = reload && ((state_q == S_RUN) || (state_q == S_ERROR));
  assign n_in      = {bus.rx_data, len_q[7:0]};
  assign last_word = (wl_q == len_q - 16'd1);

  word_packer u_packer (
    .clk          (clk),
    .rst          (PCreset),
    .clear        (restart),
    .byte_valid_i (data_byte),
    .byte_i       (bus.rx_data),
    .last_byte_o  (pk_last),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) begin
        if (32'(n_in) > MAX_WORDS) state_d = S_ERROR;
        else if (n_in == 16'd0)    state_d = S_CHECK;
        else                       state_d = S_DATA;
      end
      S_DATA:   if (data_byte && pk_last && last_word) state_d = S_CHECK;
      S_CHECK:  if (xfer) state_d = (bus.rx_data == chk_q) ? S_RUN : S_ERROR;
      S_RUN,
      S_ERROR:  if (reload) state_d = S_LEN_LO;
      default:  state_d = S_LEN_LO;
    endcase
  end

  // Status outputs are registered from the next state so they move together with it.
  always_ff @(posedge clk) begin
    if (PCreset) begin
      state_q      <= S_LEN_LO;
      len_q        <= '0;
      chk_q        <= CHK_INIT;
      wl_q         <= '0;
      addr_q       <= BASE_ADDR;
      rx_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= is_loading(state_d);
      core_reset_q <= (state_d != S_RUN);
      done_q       <= (state_d == S_RUN);
      err_q        <= (state_d == S_ERROR);
      if (xfer && (state_q == S_LEN_LO)) len_q[7:0]  <= bus.rx_data;
      if (xfer && (state_q == S_LEN_HI)) len_q[15:8] <= bus.rx_data;
      if (data_byte) begin
        chk_q <= chk_q ^ bus.rx_data;
        if (pk_last) begin
          wl_q   <= wl_q + 16'd1;
          addr_q <= BASE_ADDR + (32'(wl_q) << 2);
        end
      end
      if (restart) begin
        len_q  <= '0;
        chk_q  <= CHK_INIT;
        wl_q   <= '0;
        addr_q <= BASE_ADDR;
      end
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = pk_ready;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = pk_word;
  assign core_reset     = core_reset_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against an image-level reference model.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 256;

  logic        clk = 1'b0;
  logic        PCreset, reload;
  logic        core_reset, done, err;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] wl;
  } wr_t;
  wr_t obs[$];

  imem_boot_loader_if bus ();

  imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .PCreset      (PCreset),
    .bus          (bus.slave),
    .reload       (reload),
    .core_reset   (core_reset),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.imem_we === 1'b1) obs.push_back('{bus.imem_addr, bus.imem_wdata, words_loaded});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic send_bytes(input logic [7:0] s[$], input bit jitter);
    int idle;
    foreach (s[i]) begin
      idle = 0;
      forever begin
        @(negedge clk);
        if (jitter && $urandom_range(0, 1) == 0) begin
          bus.rx_valid = 1'b0;
          bus.rx_data  = 8'($urandom);
        end else begin
          bus.rx_valid = 1'b1;
          bus.rx_data  = s[i];
          if (bus.rx_ready === 1'b1) break;
        end
        idle++;
        if (idle > 200) begin
          n_checks++; n_fail++;
          $display("FAIL send_timeout byte %0d: rx_ready=%b, required 1", i, bus.rx_ready);
          bus.rx_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_load(input string name, input logic [31:0] words[$], input bit oversize,
                          input logic [7:0] chk_delta, input bit jitter);
    logic [7:0]  s[$];
    logic [7:0]  x;
    logic [15:0] n;
    bit          ok;
    int          nexp;
    n = oversize ? 16'(MAXW + 1) : 16'(words.size());
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    x = 8'h00;
    if (!oversize) begin
      foreach (words[i])
        for (int b = 0; b < 4; b++) begin
          s.push_back(words[i][8*b +: 8]);
          x ^= words[i][8*b +: 8];
        end
      s.push_back(x ^ chk_delta);
    end
    ok   = !oversize && (chk_delta == 8'h00);
    nexp = oversize ? 0 : words.size();
    obs.delete();
    send_bytes(s, jitter);

    n_checks++;
    if (done !== ok) begin n_fail++; $display("FAIL %s done: got %b want %b", name, done, ok); end
    n_checks++;
    if (err !== !ok) begin n_fail++; $display("FAIL %s err: got %b want %b", name, err, !ok); end
    n_checks++;
    if (core_reset !== !ok) begin
      n_fail++; $display("FAIL %s core_reset: got %b want %b", name, core_reset, !ok);
    end
    n_checks++;
    if (words_loaded !== 16'(nexp)) begin
      n_fail++; $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, nexp);
    end

    // Hold the stream busy: RUN/ERROR must not accept anything or write again.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'($urandom);
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s rx_ready_hold: got %b want 0", name, bus.rx_ready);
    end
    n_checks++;
    if (done !== ok || err !== !ok) begin
      n_fail++; $display("FAIL %s status_hold: got done=%b err=%b want done=%b err=%b", name, done, err, ok, !ok);
    end

    n_checks++;
    if (obs.size() != nexp) begin
      n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, obs.size(), nexp);
    end else begin
      for (int i = 0; i < nexp; i++) begin
        n_checks++;
        if (obs[i].a !== BASE + 32'(4 * i) || obs[i].d !== words[i] || obs[i].wl !== 16'(i + 1)) begin
          n_fail++;
          $display("FAIL %s write[%0d]: got a=%h d=%h wl=%0d want a=%h d=%h wl=%0d", name, i,
                   obs[i].a, obs[i].d, obs[i].wl, BASE + 32'(4 * i), words[i], i + 1);
        end
      end
    end
  endtask

  task automatic do_reload(input string name);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    n_checks++;
    if (core_reset !== 1'b1 || bus.rx_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || words_loaded !== 16'd0) begin
      n_fail++;
      $display("FAIL %s reload: got core_reset=%b rx_ready=%b done=%b err=%b wl=%0d want 1 1 0 0 0",
               name, core_reset, bus.rx_ready, done, err, words_loaded);
    end
  endtask

  function automatic void rand_words(output logic [31:0] w[$], input int n);
    w.delete();
    for (int i = 0; i < n; i++) w.push_back($urandom);
  endfunction

  task automatic check_reset_values(input string name);
    n_checks++;
    if (bus.rx_ready !== 1'b0 || core_reset !== 1'b1 || bus.imem_we !== 1'b0 || bus.imem_addr !== BASE ||
        bus.imem_wdata !== 32'h0 || words_loaded !== 16'd0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset_values: got rdy=%b crst=%b we=%b a=%h d=%h wl=%0d done=%b err=%b want 0 1 0 %h 0 0 0 0",
               name, bus.rx_ready, core_reset, bus.imem_we, bus.imem_addr, bus.imem_wdata,
               words_loaded, done, err, BASE);
    end
  endtask

  task automatic test_reset();
    PCreset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    PCreset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rx_ready !== 1'b1 || core_reset !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: got rdy=%b crst=%b want 1 1", bus.rx_ready, core_reset);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    w = '{32'h0050_0093, 32'h00A0_0113};
    run_load("basic", w, 1'b0, 8'h00, 1'b0);
    do_reload("basic");
  endtask

  task automatic test_bad_chk();
    logic [31:0] w[$];
    w = '{32'h0050_0093, 32'h00A0_0113};
    run_load("bad_chk", w, 1'b0, 8'h01, 1'b0);
    do_reload("bad_chk");
  endtask

  task automatic test_oversize();
    logic [31:0] w[$];
    w.delete();
    run_load("oversize", w, 1'b1, 8'h00, 1'b0);
    do_reload("oversize");
  endtask

  task automatic test_max_words();
    logic [31:0] w[$];
    rand_words(w, MAXW);
    run_load("max_words", w, 1'b0, 8'h00, 1'b0);
    do_reload("max_words");
  endtask

  task automatic test_empty();
    logic [31:0] w[$];
    w.delete();
    run_load("empty", w, 1'b0, 8'h00, 1'b0);
    do_reload("empty");
  endtask

  task automatic test_jitter_reload();
    logic [31:0] w[$];
    rand_words(w, 1);
    run_load("jitter_n1", w, 1'b0, 8'h00, 1'b1);
    do_reload("jitter_n1");
    rand_words(w, 3);
    run_load("after_reload", w, 1'b0, 8'h00, 1'b0);
    do_reload("after_reload");
  endtask

  task automatic test_reload_ignored();
    logic [31:0] w[$];
    rand_words(w, 2);
    fork
      run_load("reload_ignored", w, 1'b0, 8'h00, 1'b0);
      begin
        repeat (6) @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
    join
    do_reload("reload_ignored");
  endtask

  task automatic test_pcreset_mid();
    logic [7:0]  s[$];
    logic [31:0] w[$];
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    obs.delete();
    send_bytes(s, 1'b0);
    PCreset = 1'b1;
    @(negedge clk);
    check_reset_values("pcreset_mid");
    n_checks++;
    if (obs.size() != 1 || obs[0].d !== 32'h4433_2211) begin
      n_fail++; $display("FAIL pcreset_mid first_word: got count=%0d want 1 with 44332211", obs.size());
    end
    PCreset = 1'b0;
    @(negedge clk);
    rand_words(w, 2);
    run_load("after_pcreset", w, 1'b0, 8'h00, 1'b0);
    do_reload("after_pcreset");
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    logic [7:0]  delta;
    for (int t = 0; t < 6; t++) begin
      rand_words(w, int'($urandom_range(1, 6)));
      delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_load($sformatf("random%0d", t), w, 1'b0, delta, 1'($urandom_range(0, 1)));
      do_reload($sformatf("random%0d", t));
    end
  endtask

  initial begin
    PCreset      = 1'b1;
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_chk();
    test_oversize();
    test_max_words();
    test_empty();
    test_jitter_reload();
    test_reload_ignored();
    test_pcreset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
